vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, 2-stage sync/blank pipeline, colour expansion.
// Optional feature: define VGA_BORDER_EN to paint a BORDER_COLOR frame around the visible area.
module vga_timing_gen #(
    parameter int             H_VISIBLE    = 640,
    parameter int             H_FRONT      = 16,
    parameter int             H_SYNC       = 96,
    parameter int             H_BACK       = 48,
    parameter int             V_VISIBLE    = 480,
    parameter int             V_FRONT      = 10,
    parameter int             V_SYNC       = 2,
    parameter int             V_BACK       = 33,
    parameter logic [7:0]     BORDER_COLOR = 8'h1F
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [7:0]         RGBin,
    output logic signed [10:0] pixelX,
    output logic signed [10:0] pixelY,
    output logic               startOfFrame,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hsyncN,
    output logic               vsyncN,
    output logic               blankN
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    function automatic logic [23:0] expand(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
    endfunction

    logic [10:0] x_q, x_d, y_q, y_d;
    logic        vis, hs, vs;
    logic        vis_q, hs_q, vs_q;
    logic [7:0]  red_q, green_q, blue_q;
    logic        hsync_n_q, vsync_n_q, blank_n_q;
    logic [23:0] rgb_exp;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        x_d = x_q + 11'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
        end
    end

    assign vis = (x_q < H_VIS) && (y_q < V_VIS);
    assign hs  = (x_q >= HS_START) && (x_q < HS_END);
    assign vs  = (y_q >= VS_START) && (y_q < VS_END);

`ifdef VGA_BORDER_EN
    logic [10:0] xd_q, yd_q;
    logic        on_border;

    assign on_border = (xd_q == '0) || (xd_q == H_VIS - 11'd1) ||
                       (yd_q == '0) || (yd_q == V_VIS - 11'd1);
    assign rgb_exp   = on_border ? expand(BORDER_COLOR) : expand(RGBin);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            xd_q <= '0;
            yd_q <= '0;
        end else begin
            xd_q <= x_q;
            yd_q <= y_q;
        end
    end
`else
    assign rgb_exp = expand(RGBin);
`endif

    // NOTE: sequential state uses non-blocking assignments only; the async reset puts every flop in a known state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            x_q       <= '0;
            y_q       <= '0;
            vis_q     <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vis_q     <= vis;
            hs_q      <= hs;
            vs_q      <= vs;
            // RGBin arrives one clock after its coordinate, aligned with the first pipeline stage.
            red_q     <= vis_q ? rgb_exp[23:16] : '0;
            green_q   <= vis_q ? rgb_exp[15:8]  : '0;
            blue_q    <= vis_q ? rgb_exp[7:0]   : '0;
            hsync_n_q <= ~hs_q;
            vsync_n_q <= ~vs_q;
            blank_n_q <= vis_q;
        end
    end

    assign pixelX       = $signed(x_q);
    assign pixelY       = $signed(y_q);
    assign startOfFrame = (x_q == '0) && (y_q == '0);
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign hsyncN       = hsync_n_q;
    assign vsyncN       = vsync_n_q;
    assign blankN       = blank_n_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen, using a shortened raster so two frames stay small.
// Horizontal sync width (96) and porch structure are kept; expectations follow the scaled geometry.
module tb_vga_timing_gen;

    localparam int HV = 160, HF = 16, HS = 96, HB = 8;
    localparam int VV = 56,  VF = 4,  VS = 2,  VB = 2;
    localparam int HT = HV + HF + HS + HB;      // 280
    localparam int VT = VV + VF + VS + VB;      // 64
    localparam int FRAME = HT * VT;             // 17920
    localparam logic [7:0] BCOL = 8'h1F;

    logic               clk = 1'b0;
    logic               resetN;
    logic [7:0]         RGBin;
    logic signed [10:0] pixelX, pixelY;
    logic               startOfFrame;
    logic [7:0]         red, green, blue;
    logic               hsyncN, vsyncN, blankN;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .BORDER_COLOR(BCOL)
    ) dut (
        .clk(clk), .resetN(resetN), .RGBin(RGBin),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .red(red), .green(green), .blue(blue),
        .hsyncN(hsyncN), .vsyncN(vsyncN), .blankN(blankN)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_xy(input int x, input int y, output bit ok);
        int n = 0;
        while (!(pixelX == x && pixelY == y) && n < FRAME + 8) begin
            @(negedge clk);
            n++;
        end
        ok = (pixelX == x && pixelY == y);
    endtask

    // Follows the raster from a startOfFrame for nframes frames, checking it against the timing formulas.
    task automatic run_frames(input int nframes, input string tag);
        int n = 0, last_sof = 0, sofs = 0, bad_intv = 0, bad_dec = 0, bad_cnt = 0;
        int bad_sync = 0, bad_run = 0, runs = 0, hrun = 0, vlow = 0;
        int x0, y0, x1 = 0, y1 = 0, x2 = 0, y2 = 0;
        bit vis2, hs2, vs2;
        while (startOfFrame !== 1'b1 && n < FRAME + 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sof_found"}, 32'(startOfFrame), 1);
        for (int c = 0; c <= nframes * FRAME; c++) begin
            if (c > 0) @(negedge clk);
            x0 = int'(pixelX);
            y0 = int'(pixelY);
            if (startOfFrame === 1'b1) begin
                if (sofs > 0 && c - last_sof != FRAME) bad_intv++;
                last_sof = c;
                sofs++;
            end
            if (startOfFrame !== (x0 == 0 && y0 == 0)) bad_dec++;
            if (c > 0 && (x0 != (x1 + 1) % HT ||
                          y0 != ((x1 == HT - 1) ? (y1 + 1) % VT : y1))) bad_cnt++;
            if (c >= 2) begin
                vis2 = (x2 < HV) && (y2 < VV);
                hs2  = (x2 >= HV + HF) && (x2 < HV + HF + HS);
                vs2  = (y2 >= VV + VF) && (y2 < VV + VF + VS);
                if (hsyncN !== !hs2 || vsyncN !== !vs2 || blankN !== vis2) bad_sync++;
            end
            if (hsyncN === 1'b0) hrun++;
            else if (hrun != 0) begin
                runs++;
                if (hrun != HS) bad_run++;
                hrun = 0;
            end
            if (vsyncN === 1'b0) vlow++;
            x2 = x1; y2 = y1;
            x1 = x0; y1 = y0;
        end
        check({tag, "_sof_count"},    sofs,     nframes + 1);
        check({tag, "_sof_interval"}, bad_intv, 0);
        check({tag, "_sof_decode"},   bad_dec,  0);
        check({tag, "_counters"},     bad_cnt,  0);
        check({tag, "_sync_blank"},   bad_sync, 0);
        check({tag, "_hsync_width"},  bad_run,  0);
        check({tag, "_hsync_lines"},  runs,     nframes * VT);
        check({tag, "_vsync_low"},    vlow,     nframes * VS * HT);
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [7:0] rgb;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank;
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;

        // Border colour 1F expands to r=00, g=FF, b=FF.
`ifdef VGA_BORDER_EN
        vec[0] = '{0,   0,  8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1};
        vec[3] = '{0,   10, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1};
        vec[7] = '{159, 50, 8'h6D, 8'h00, 8'hFF, 8'hFF, 1'b1};
        vec[9] = '{10,  55, 8'h92, 8'h00, 8'hFF, 8'hFF, 1'b1};
`else
        vec[0] = '{0,   0,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vec[3] = '{0,   10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vec[7] = '{159, 50, 8'h6D, 8'h6D, 8'h6D, 8'h55, 1'b1};
        vec[9] = '{10,  55, 8'h92, 8'h92, 8'h92, 8'hAA, 1'b1};
`endif
        vec[1]  = '{1,   1,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vec[2]  = '{10,  5,  8'h1C, 8'h00, 8'hFF, 8'h00, 1'b1};
        vec[4]  = '{100, 50, 8'hE0, 8'hFF, 8'h00, 8'h00, 1'b1};
        vec[5]  = '{120, 50, 8'h03, 8'h00, 8'h00, 8'hFF, 1'b1};
        vec[6]  = '{140, 50, 8'h92, 8'h92, 8'h92, 8'hAA, 1'b1};
        vec[8]  = '{160, 50, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        vec[10] = '{10,  56, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};

        resetN = 1'b0;
        RGBin  = 8'hFF;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_pixelX", 32'(pixelX), 0);
        check("rst_pixelY", 32'(pixelY), 0);
        check("rst_red",    32'(red),    0);
        check("rst_green",  32'(green),  0);
        check("rst_blue",   32'(blue),   0);
        check("rst_hsyncN", 32'(hsyncN), 1);
        check("rst_vsyncN", 32'(vsyncN), 1);
        check("rst_blankN", 32'(blankN), 0);
        resetN = 1'b1;
        #1;
        check("rel_pixelX", 32'(pixelX),       0);
        check("rel_pixelY", 32'(pixelY),       0);
        check("rel_sof",    32'(startOfFrame), 1);

        for (int i = 0; i < NV; i++) begin
            wait_xy(vec[i].x, vec[i].y, ok);
            check($sformatf("reach_%0d_%0d", vec[i].x, vec[i].y), 32'(ok), 1);
            @(posedge clk);
            #1 RGBin = vec[i].rgb;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("red_%0d_%0d",    vec[i].x, vec[i].y), 32'(red),    32'(vec[i].r));
            check($sformatf("green_%0d_%0d",  vec[i].x, vec[i].y), 32'(green),  32'(vec[i].g));
            check($sformatf("blue_%0d_%0d",   vec[i].x, vec[i].y), 32'(blue),   32'(vec[i].b));
            check($sformatf("blankN_%0d_%0d", vec[i].x, vec[i].y), 32'(blankN), 32'(vec[i].blank));
        end
        RGBin = 8'h00;

        run_frames(2, "run");

        // Mid-frame reset while hsync is active: counters and syncs must clear without a clock edge.
        wait_xy(250, 10, ok);
        check("reach_250_10", 32'(ok), 1);
        #1 resetN = 1'b0;
        #1;
        check("async_pixelX", 32'(pixelX), 0);
        check("async_pixelY", 32'(pixelY), 0);
        check("async_hsyncN", 32'(hsyncN), 1);
        check("async_vsyncN", 32'(vsyncN), 1);
        check("async_blankN", 32'(blankN), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_pixelX", 32'(pixelX), 0);
        resetN = 1'b1;
        #1;
        check("rel2_pixelX", 32'(pixelX),       0);
        check("rel2_pixelY", 32'(pixelY),       0);
        check("rel2_sof",    32'(startOfFrame), 1);

        run_frames(1, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
